// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory and holds the CPU until verified
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [15:0] idx_next;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic        accept;

  assign accept   = byte_valid & byte_ready;
  assign idx_next = idx + 16'd1;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          timeout;

  // byte_ready doubles as "in a receive state", so the idle count only runs there
  assign timeout = byte_ready && !accept && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 16'd0;
      wr_data    <= 16'd0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      len        <= 16'd0;
      idx        <= 16'd0;
      hi_byte    <= 8'd0;
      csum       <= 8'd0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LEN_HI;
            byte_ready <= 1'b1;
            idx        <= 16'd0;
            csum       <= 8'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            if ({1'b0, len[15:8], byte_data} > 17'(DEPTH_WORDS)) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              err        <= 1'b1;
            end else if ({len[15:8], byte_data} == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_byte <= byte_data;
            csum    <= csum ^ byte_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            csum    <= csum ^ byte_data;
            wr_en   <= 1'b1;
            wr_data <= {hi_byte, byte_data};
            wr_addr <= {idx[14:0], 1'b0};
            idx     <= idx_next;
            state   <= (idx_next == len) ? CHECK : DATA_HI;
          end
        end
        CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
      if (!byte_ready || accept) tcnt <= '0;
      else                       tcnt <= tcnt + TW'(1);
      // Placed after the case so a stalled stream overrides the hold-in-place default
      if (timeout) begin
        state      <= ERROR;
        byte_ready <= 1'b0;
        err        <= 1'b1;
        cpu_hold   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stream[$];
  logic [31:0] got[$];
  logic [31:0] exp_w[$];
  logic        exp_done;
  int          exp_bytes;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always @(negedge clk) if (rst === 1'b1 && wr_en === 1'b1) got.push_back({wr_addr, wr_data});

  // Reference: parse the stream as the image format describes it
  task automatic model();
    int n;
    logic [7:0] cs;
    exp_w.delete();
    n  = {stream[0], stream[1]};
    cs = 8'h00;
    if (n > DEPTH) begin
      exp_done  = 1'b0;
      exp_bytes = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({16'(2 * i), stream[2 + 2 * i], stream[3 + 2 * i]});
      cs ^= stream[2 + 2 * i] ^ stream[3 + 2 * i];
    end
    exp_done  = (stream[2 + 2 * n] == cs);
    exp_bytes = 2 + 2 * n + 1;
  endtask

  task automatic gen_image(input int n, input bit corrupt);
    logic [7:0] b;
    logic [7:0] cs;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    cs = 8'h00;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      cs ^= b;
      stream.push_back(b);
    end
    if (corrupt) cs ^= 8'($urandom_range(1, 255));
    stream.push_back(cs);
  endtask

  task automatic do_start();
    @(negedge clk);
    got.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Random idle gaps carry garbage data and stray start pulses, which must be ignored
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   acc;
    acc = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      start      = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 50 && !acc; k++) begin
      rdy = byte_ready;
      @(posedge clk);
      if (rdy === 1'b1) acc = 1'b1;
      else @(negedge clk);
    end
    #1 byte_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake: byte_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic send_count(input int cnt);
    for (int i = 0; i < cnt; i++) send_byte(stream[i]);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if ({wr_addr, wr_data} !== 32'h0) begin errors++; $display("FAIL reset_wr: got %h want 0", {wr_addr, wr_data}); end
    checks++; if ({cpu_hold, done, err} !== 3'b100) begin errors++; $display("FAIL reset_flags: hold/done/err got %b want 100", {cpu_hold, done, err}); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({byte_ready, cpu_hold, done, err} !== 4'b0100) begin errors++; $display("FAIL idle_flags: got %b want 0100", {byte_ready, cpu_hold, done, err}); end
  endtask

  task automatic test_known_images();
    for (int c = 0; c < 4; c++) begin
      stream.delete();
      case (c)
        0: stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        1: stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        2: stream = '{8'h00, 8'h00, 8'h00};
        default: stream = '{8'h00, 8'h00, 8'h01};
      endcase
      model();
      do_start();
      send_count(exp_bytes);
      checks++; if (got.size() != exp_w.size()) begin errors++; $display("FAIL known%0d_nwrites: got %0d want %0d", c, got.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL known%0d_write%0d: got %h want %h", c, i, got[i], exp_w[i]); end
      end
      if (c == 0 && got.size() == 2) begin
        checks++; if (got[0] !== 32'h0000_1234 || got[1] !== 32'h0002_ABCD) begin errors++; $display("FAIL known0_literal: got %h %h want 00001234 0002abcd", got[0], got[1]); end
      end
      checks++; if ({done, err, cpu_hold} !== {exp_done, !exp_done, !exp_done}) begin errors++; $display("FAIL known%0d_status: done/err/hold got %b want %b", c, {done, err, cpu_hold}, {exp_done, !exp_done, !exp_done}); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL known%0d_ready: got %b want 0", c, byte_ready); end
    end
  endtask

  task automatic test_len_reject();
    int lens[2] = '{257, 16'h8000};
    foreach (lens[j]) begin
      gen_image(0, 1'b0);
      stream[0] = 8'(lens[j] >> 8);
      stream[1] = 8'(lens[j]);
      model();
      do_start();
      send_count(exp_bytes);
      checks++; if (got.size() != 0) begin errors++; $display("FAIL reject%0d_writes: got %0d want 0", j, got.size()); end
      checks++; if ({err, done, cpu_hold, byte_ready} !== 4'b1010) begin errors++; $display("FAIL reject%0d_status: err/done/hold/ready got %b want 1010", j, {err, done, cpu_hold, byte_ready}); end
    end
  endtask

  task automatic test_random_images();
    int n;
    for (int it = 0; it < 12; it++) begin
      n = (it == 0) ? DEPTH : $urandom_range(1, 12);
      gen_image(n, ($urandom_range(0, 3) == 0));
      model();
      do_start();
      send_count(exp_bytes);
      checks++; if (got.size() != exp_w.size()) begin errors++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, got.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL rand%0d_write%0d: got %h want %h", it, i, got[i], exp_w[i]); end
      end
      checks++; if ({done, err, cpu_hold} !== {exp_done, !exp_done, !exp_done}) begin errors++; $display("FAIL rand%0d_status: done/err/hold got %b want %b", it, {done, err, cpu_hold}, {exp_done, !exp_done, !exp_done}); end
    end
  endtask

  task automatic test_reset_mid_load();
    gen_image(3, 1'b0);
    model();
    do_start();
    for (int i = 0; i < 4; i++) send_byte(stream[i]);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if ({wr_en, byte_ready, cpu_hold, done, err} !== 5'b00100) begin errors++; $display("FAIL abort_flags: got %b want 00100", {wr_en, byte_ready, cpu_hold, done, err}); end
    checks++; if ({wr_addr, wr_data} !== 32'h0) begin errors++; $display("FAIL abort_wr: got %h want 0", {wr_addr, wr_data}); end
    repeat (4) @(negedge clk);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL abort_nwrites: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      checks++; if (got[0] !== exp_w[0]) begin errors++; $display("FAIL abort_write0: got %h want %h", got[0], exp_w[0]); end
    end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL abort_hold: got %b want 1", cpu_hold); end
    rst = 1'b1;
    gen_image(3, 1'b0);
    model();
    do_start();
    send_count(exp_bytes);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL reload_nwrites: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL reload_write%0d: got %h want %h", i, got[i], exp_w[i]); end
    end
    checks++; if ({done, err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL reload_status: done/err/hold got %b want 100", {done, err, cpu_hold}); end
  endtask

  task automatic test_timeout();
    do_start();
`ifdef IMEM_LOADER_TIMEOUT_EN
    repeat (TMO - 1) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_early: err got %b want 0", err); end
    @(negedge clk);
    checks++; if ({err, cpu_hold, byte_ready} !== 3'b110) begin errors++; $display("FAIL timeout_fire: err/hold/ready got %b want 110", {err, cpu_hold, byte_ready}); end
`else
    repeat (1000) @(negedge clk);
    checks++; if ({err, byte_ready, cpu_hold} !== 3'b011) begin errors++; $display("FAIL no_timeout: err/ready/hold got %b want 011", {err, byte_ready, cpu_hold}); end
`endif
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_known_images();
    test_len_reject();
    test_random_images();
    test_reset_mid_load();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that writes the instruction memory the CPU fetches from. It accepts a byte stream over a valid/ready handshake and assembles 16-bit instructions. It writes them to byte addresses 0, 2, 4, and so on, matching the PC step of 2. It holds the CPU in reset until a checksummed image has loaded completely.

Parameters:
DEPTH_WORDS, 256, maximum instruction words accepted; larger length headers are rejected.
TIMEOUT_CYCLES, 1024, inter-byte timeout in clk cycles; used only when IMEM_LOADER_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  begin a load; sampled only in IDLE, DONE, ERROR.
byte_valid  in  1  byte_data is valid.
byte_data  in  8  stream byte.
byte_ready  out  1  loader can accept a byte this cycle.
wr_en  out  1  one-cycle instruction-memory write strobe.
wr_addr  out  16  byte address of the write (always even).
wr_data  out  16  instruction word, {high byte, low byte}.
cpu_hold  out  1  high keeps the CPU in reset.
done  out  1  image loaded and verified.
err  out  1  load failed (bad length, bad checksum, or timeout).

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0.
  - Internal counters and checksum cleared.
- Handshake: a byte is accepted on a rising clk edge when byte_valid=1 and byte_ready=1.
- byte_ready is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
- Stream format:
  - LEN_HI, LEN_LO: word count N, big-endian.
  - 2N instruction bytes, high byte first.
  - One checksum byte equal to the XOR of all 2N instruction bytes.
- State transitions:
  - IDLE: start=1 goes to LEN_HI; clear the word index and checksum.
  - LEN_HI: on accept, latch N[15:8]; go to LEN_LO.
  - LEN_LO: on accept, latch N[7:0]. If N > DEPTH_WORDS go to ERROR. If N = 0 go to CHECK. Otherwise go to DATA_HI.
  - DATA_HI: on accept, latch the high byte, XOR it into the checksum, go to DATA_LO.
  - DATA_LO: on accept, XOR the byte into the checksum. Next cycle: wr_en=1, wr_data={hi, lo}, wr_addr = 2 × word index. Then increment the word index. Go to CHECK if the index has reached N, otherwise DATA_HI.
  - CHECK: on accept, go to DONE if the byte equals the running checksum, otherwise ERROR.
  - DONE: done=1, cpu_hold=0. start=1 returns to LEN_HI with done=0 and cpu_hold=1 again.
  - ERROR: err=1, cpu_hold=1. start=1 returns to LEN_HI with err cleared.
- wr_en is high for exactly one cycle per word; write latency is 1 cycle after the low-byte accept.
- The address wraps modulo 2^16; this cannot occur while DEPTH_WORDS ≤ 32768.
- start asserted in any receive state is ignored.
- Bytes presented while byte_ready=0 are not consumed.
- Asynchronous reset mid-load aborts immediately. No further wr_en is issued, and cpu_hold stays 1.
- No simultaneous-event conflict exists: only one byte can be accepted per cycle.

Optional Feature:
IMEM_LOADER_TIMEOUT_EN:
- Defined:
  - A counter runs in LEN_HI through CHECK and resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, the loader goes to ERROR (err=1, cpu_hold=1).
  - The counter is cleared on entry to LEN_HI.
- Undefined: no counter is built, and the loader waits indefinitely for bytes.

Test Plan:
- Load N=2, bytes 12 34 AB CD, checksum 0x40 -> wr_en pulses at addr 0x0000 data 0x1234, then addr 0x0002 data 0xABCD; done=1, cpu_hold=0, err=0.
- Load N=2 with checksum 0x41 -> both writes occur, then err=1, done=0, cpu_hold=1.
- Header N=0x0101 (257 > 256) -> ERROR straight after LEN_LO; no wr_en pulse; err=1.
- Header N=0, checksum 0x00 -> done=1 with no writes; checksum 0x01 -> err=1.
- Drive rst low after the first DATA_LO accept of an N=3 load -> outputs return to reset values immediately; exactly one write was seen; a subsequent start plus a full stream loads correctly from addr 0.
- With IMEM_LOADER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: stop sending after LEN_HI -> err=1 after 16 idle cycles. Without the macro: still waiting after 1000 cycles, err=0.
